// File: rtl/enemy_control.sv
// Single enemy bomber: spawns at a fixed entry point and flies one DAC step
// per speed tick toward its target base until it arrives or is destroyed.
package vector_pkg;
    localparam int DAC_WIDTH = 8;
endpackage

package ROM_pkg;
    localparam int X_BASE1 = 64;
    localparam int Y_BASE1 = 16;
    localparam int X_BASE2 = 128;
    localparam int Y_BASE2 = 24;
    localparam int X_BASE3 = 192;
    localparam int Y_BASE3 = 16;
endpackage

module enemy_control
    import vector_pkg::*;
    import ROM_pkg::*;
#(
    parameter int OUT_WIDTH   = DAC_WIDTH,
    parameter int TARGET_BASE = 1,
    parameter int X_START     = 0,
    parameter int Y_START     = 2**OUT_WIDTH-1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 spawn_pulse,
    input  logic                 speed_pulse,
    output logic                 spawn,
    output logic [OUT_WIDTH-1:0] xenemy,
    output logic [OUT_WIDTH-1:0] yenemy
);

    // Unknown base selects fall back to base 1
    localparam int TXI = (TARGET_BASE == 2) ? X_BASE2 :
                         (TARGET_BASE == 3) ? X_BASE3 : X_BASE1;
    localparam int TYI = (TARGET_BASE == 2) ? Y_BASE2 :
                         (TARGET_BASE == 3) ? Y_BASE3 : Y_BASE1;

    localparam logic [OUT_WIDTH-1:0] TX = OUT_WIDTH'(TXI);
    localparam logic [OUT_WIDTH-1:0] TY = OUT_WIDTH'(TYI);
    localparam logic [OUT_WIDTH-1:0] XS = OUT_WIDTH'(X_START);
    localparam logic [OUT_WIDTH-1:0] YS = OUT_WIDTH'(Y_START);

    typedef enum logic [1:0] {
        IDLE,
        FLYING,
        ARRIVED
    } state_t;

    state_t                 state_q, state_d;
    logic [OUT_WIDTH-1:0]   x_q, x_d;
    logic [OUT_WIDTH-1:0]   y_q, y_d;
    logic                   spawn_q, spawn_d;

    // Compare before stepping so the coordinate can never overshoot or wrap
    function automatic logic [OUT_WIDTH-1:0] step_to(
        input logic [OUT_WIDTH-1:0] cur,
        input logic [OUT_WIDTH-1:0] tgt
    );
        if (cur < tgt)
            return cur + 1'b1;
        else if (cur > tgt)
            return cur - 1'b1;
        else
            return cur;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= XS;
            y_q     <= YS;
            spawn_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            spawn_q <= spawn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        if (!en) begin
            state_d = IDLE;
            x_d     = XS;
            y_d     = YS;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (spawn_pulse) begin
                        state_d = FLYING;
                        x_d     = XS;
                        y_d     = YS;
                    end
                end
                FLYING: begin
                    if (x_q == TX && y_q == TY) begin
                        state_d = ARRIVED;
                    end else if (speed_pulse) begin
                        x_d = step_to(x_q, TX);
                        y_d = step_to(y_q, TY);
                    end
                end
                ARRIVED: begin
                    state_d = ARRIVED;
                end
                default: begin
                    state_d = IDLE;
                    x_d     = XS;
                    y_d     = YS;
                end
            endcase
        end
        spawn_d = (state_d != IDLE);
    end

    assign spawn  = spawn_q;
    assign xenemy = x_q;
    assign yenemy = y_q;

endmodule

// File: tb/tb_enemy_control.sv
// Bench for enemy_control: four instances (bases 1, 2, 3 and invalid 0)
// share stimulus; a per-cycle reference model feeds a scoreboard queue.
module tb_enemy_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       spawn_pulse = 1'b0;
    logic       speed_pulse = 1'b0;
    logic       sp [4];
    logic [7:0] xo [4];
    logic [7:0] yo [4];

    int n_chk  = 0;
    int n_pass = 0;

    int TXV [4] = '{64, 128, 192, 64};
    int TYV [4] = '{16, 24, 16, 16};

    int         mst [4];
    logic [7:0] mx [4];
    logic [7:0] my [4];

    logic [3:0][16:0] sbq [$];

    always #5 clk = ~clk;

    enemy_control #(.TARGET_BASE(1)) u_b1 (
        .clk(clk), .rst(rst), .en(en),
        .spawn_pulse(spawn_pulse), .speed_pulse(speed_pulse),
        .spawn(sp[0]), .xenemy(xo[0]), .yenemy(yo[0])
    );
    enemy_control #(.TARGET_BASE(2)) u_b2 (
        .clk(clk), .rst(rst), .en(en),
        .spawn_pulse(spawn_pulse), .speed_pulse(speed_pulse),
        .spawn(sp[1]), .xenemy(xo[1]), .yenemy(yo[1])
    );
    enemy_control #(.TARGET_BASE(3)) u_b3 (
        .clk(clk), .rst(rst), .en(en),
        .spawn_pulse(spawn_pulse), .speed_pulse(speed_pulse),
        .spawn(sp[2]), .xenemy(xo[2]), .yenemy(yo[2])
    );
    enemy_control #(.TARGET_BASE(0)) u_b0 (
        .clk(clk), .rst(rst), .en(en),
        .spawn_pulse(spawn_pulse), .speed_pulse(speed_pulse),
        .spawn(sp[3]), .xenemy(xo[3]), .yenemy(yo[3])
    );

    task automatic check(input string tag, input logic [16:0] got,
                         input logic [16:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got spawn=%0b x=%0d y=%0d, need spawn=%0b x=%0d y=%0d",
                      tag, got[16], got[15:8], got[7:0],
                      exp[16], exp[15:8], exp[7:0]);
    endtask

    function automatic logic [7:0] towards(input logic [7:0] c, input int t);
        if (int'(c) < t) return c + 8'd1;
        if (int'(c) > t) return c - 8'd1;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mst[i] = 0;
            mx[i]  = 8'd0;
            my[i]  = 8'd255;
        end
    endtask

    task automatic model_step(input logic e, input logic s, input logic v);
        for (int i = 0; i < 4; i++) begin
            if (!e) begin
                mst[i] = 0;
                mx[i]  = 8'd0;
                my[i]  = 8'd255;
            end else if (mst[i] == 0) begin
                if (s) mst[i] = 1;
            end else if (mst[i] == 1) begin
                if (int'(mx[i]) == TXV[i] && int'(my[i]) == TYV[i]) mst[i] = 2;
                else if (v) begin
                    mx[i] = towards(mx[i], TXV[i]);
                    my[i] = towards(my[i], TYV[i]);
                end
            end
        end
    endtask

    task automatic cycle(input logic e, input logic s, input logic v);
        logic [3:0][16:0] exp;
        @(negedge clk);
        en = e;
        spawn_pulse = s;
        speed_pulse = v;
        model_step(e, s, v);
        for (int i = 0; i < 4; i++)
            exp[i] = {(mst[i] != 0), mx[i], my[i]};
        sbq.push_back(exp);
        @(posedge clk);
        #1;
        exp = sbq.pop_front();
        for (int i = 0; i < 4; i++)
            check($sformatf("cyc_b%0d", i), {sp[i], xo[i], yo[i]}, exp[i]);
    endtask

    task automatic fly(input int ticks, input int respawn_at);
        for (int t = 1; t <= ticks; t++) begin
            repeat (9) cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b1, (t == respawn_at), 1'b1);
        end
    endtask

    initial begin
        int first_hit;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            check($sformatf("reset_b%0d", i), {sp[i], xo[i], yo[i]},
                  {1'b0, 8'd0, 8'd255});
        @(negedge clk);
        rst = 1'b0;

        repeat (1000) cycle(1'b1, 1'b0, 1'b0);

        cycle(1'b1, 1'b1, 1'b0);
        first_hit = -1;
        for (int t = 1; t <= 260; t++) begin
            repeat (9) cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b1, (t == 100), 1'b1);
            if (first_hit < 0 && xo[0] == 8'd64) first_hit = t;
        end
        check("x_base1_ticks", 17'(first_hit), 17'd64);
        check("arrived_b3", {sp[2], xo[2], yo[2]}, {1'b1, 8'd192, 8'd16});

        repeat (10) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 1'b1);
        fly(20, 5);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);

        cycle(1'b1, 1'b1, 1'b0);
        fly(10, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 4; i++)
            check($sformatf("async_rst_b%0d", i), {sp[i], xo[i], yo[i]},
                  {1'b0, 8'd0, 8'd255});
        @(negedge clk);
        rst = 1'b0;
        repeat (5) cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        fly(5, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
